// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target over a word-addressed memory with fixed response latency.
// Optional stall injection is built when WB_TGT_MEM_STALL_INJECT_EN is defined.
module wb_tgt_mem #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 2,
  parameter int TGD_WIDTH = 1,
  parameter int MEM_AW    = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk_i,
  input  logic                 async_rst_i,
  input  logic                 tgt_cyc_i,
  input  logic                 tgt_stb_i,
  input  logic                 tgt_we_i,
  input  logic                 tgt_lock_i,
  input  logic [SEL_WIDTH-1:0] tgt_sel_i,
  input  logic [ADR_WIDTH-1:0] tgt_adr_i,
  input  logic [DAT_WIDTH-1:0] tgt_dat_i,
  input  logic [TGD_WIDTH-1:0] tgt_tgd_i,
  output logic                 tgt_ack_o,
  output logic                 tgt_err_o,
  output logic                 tgt_rty_o,
  output logic                 tgt_stall_o,
  output logic [DAT_WIDTH-1:0] tgt_dat_o,
  output logic [TGD_WIDTH-1:0] tgt_tgd_o
);
  localparam int LANE_W = DAT_WIDTH / SEL_WIDTH;
  localparam int DEPTH  = 1 << MEM_AW;

  logic [DAT_WIDTH-1:0] mem_q [DEPTH];
  logic [TGD_WIDTH-1:0] tag_q [DEPTH];

  logic [MEM_AW-1:0]    idx_s;
  logic                 oor_s;
  logic                 acc_s;
  logic                 wr_s;
  logic                 rd_s;
  logic                 stall_s;
  logic                 unused_s;

  logic                 vld_q [LATENCY];
  logic                 err_q [LATENCY];
  logic [DAT_WIDTH-1:0] dat_q [LATENCY];
  logic [TGD_WIDTH-1:0] tgd_q [LATENCY];

  logic                 s0_vld_d;
  logic                 s0_err_d;
  logic [DAT_WIDTH-1:0] s0_dat_d;
  logic [TGD_WIDTH-1:0] s0_tgd_d;

  logic                 rsp_ack_q, rsp_ack_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [TGD_WIDTH-1:0] rsp_tgd_q, rsp_tgd_d;

  assign unused_s = tgt_lock_i;
  assign idx_s    = tgt_adr_i[MEM_AW-1:0];

  generate
    if (MEM_AW < ADR_WIDTH) begin : g_oor
      assign oor_s = |tgt_adr_i[ADR_WIDTH-1:MEM_AW];
    end else begin : g_no_oor
      assign oor_s = 1'b0;
    end
  endgenerate

`ifdef WB_TGT_MEM_STALL_INJECT_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       stall_q, stall_d;

  // Fibonacci LFSR (taps 8,6,5,4) and the registered stall derived from it.
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    stall_d = lfsr_q[0] & lfsr_q[1];
  end

  // Stall generator state.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      lfsr_q  <= 8'h01;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end

  assign stall_s = stall_q;
`else
  assign stall_s = 1'b0;
`endif

  assign acc_s = tgt_cyc_i & tgt_stb_i & ~stall_s;
  assign wr_s  = acc_s & tgt_we_i & ~oor_s;
  assign rd_s  = acc_s & ~tgt_we_i & ~oor_s;

  // Lane-masked memory write; storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (tgt_sel_i[i]) begin
          mem_q[idx_s][i*LANE_W +: LANE_W] <= tgt_dat_i[i*LANE_W +: LANE_W];
        end
      end
      if (|tgt_sel_i) begin
        tag_q[idx_s] <= tgt_tgd_i;
      end
    end
  end

  // Stage-0 load: writes and errors carry zero data, reads capture the word.
  always_comb begin
    s0_vld_d = acc_s;
    s0_err_d = acc_s & oor_s;
    s0_dat_d = {DAT_WIDTH{1'b0}};
    s0_tgd_d = {TGD_WIDTH{1'b0}};
    if (rd_s) begin
      s0_dat_d = mem_q[idx_s];
      s0_tgd_d = tag_q[idx_s];
    end else begin
      s0_dat_d = {DAT_WIDTH{1'b0}};
      s0_tgd_d = {TGD_WIDTH{1'b0}};
    end
  end

  // Response shift register; a dropped cycle kills everything in flight.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= {DAT_WIDTH{1'b0}};
        tgd_q[i] <= {TGD_WIDTH{1'b0}};
      end
    end else begin
      vld_q[0] <= s0_vld_d;
      err_q[0] <= s0_err_d;
      dat_q[0] <= s0_dat_d;
      tgd_q[0] <= s0_tgd_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1] & tgt_cyc_i;
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
        tgd_q[i] <= tgd_q[i-1];
      end
    end
  end

  // Output register next state: present the last stage, hold data otherwise.
  always_comb begin
    rsp_ack_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_dat_d = rsp_dat_q;
    rsp_tgd_d = rsp_tgd_q;
    if (tgt_cyc_i && vld_q[LATENCY-1]) begin
      rsp_ack_d = ~err_q[LATENCY-1];
      rsp_err_d = err_q[LATENCY-1];
      rsp_dat_d = dat_q[LATENCY-1];
      rsp_tgd_d = tgd_q[LATENCY-1];
    end else begin
      rsp_ack_d = 1'b0;
      rsp_err_d = 1'b0;
      rsp_dat_d = rsp_dat_q;
      rsp_tgd_d = rsp_tgd_q;
    end
  end

  // Registered bus outputs.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      rsp_ack_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= {DAT_WIDTH{1'b0}};
      rsp_tgd_q <= {TGD_WIDTH{1'b0}};
    end else begin
      rsp_ack_q <= rsp_ack_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_tgd_q <= rsp_tgd_d;
    end
  end

  assign tgt_ack_o   = rsp_ack_q;
  assign tgt_err_o   = rsp_err_q;
  assign tgt_rty_o   = 1'b0;
  assign tgt_stall_o = stall_s;
  assign tgt_dat_o   = rsp_dat_q;
  assign tgt_tgd_o   = rsp_tgd_q;

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Self-checking bench for wb_tgt_mem: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_wb_tgt_mem;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int TW  = 1;
  localparam int MAW = 8;
  localparam int LAT = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc, stb, we, lock;
  logic [SW-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [TW-1:0] tgd_w;
  logic          ack, err, rty, stall;
  logic [DW-1:0] dat_r;
  logic [TW-1:0] tgd_r;

  always #5 clk = ~clk;

  wb_tgt_mem #(
    .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW),
    .TGD_WIDTH(TW), .MEM_AW(MAW), .LATENCY(LAT)
  ) dut (
    .clk_i(clk), .async_rst_i(rst_n),
    .tgt_cyc_i(cyc), .tgt_stb_i(stb), .tgt_we_i(we), .tgt_lock_i(lock),
    .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(dat_w), .tgt_tgd_i(tgd_w),
    .tgt_ack_o(ack), .tgt_err_o(err), .tgt_rty_o(rty), .tgt_stall_o(stall),
    .tgt_dat_o(dat_r), .tgt_tgd_o(tgd_r)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  typedef struct {
    int            due;
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
    logic [TW-1:0] tgd;
  } rsp_t;

  typedef struct {
    int            cyc;
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
  } ev_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [TW-1:0] tgd;
    logic          e_ack;
    logic          e_err;
    logic [DW-1:0] e_dat;
    logic [TW-1:0] e_tgd;
  } vec_t;

  logic [DW-1:0] m_mem [1 << MAW];
  logic [TW-1:0] m_tag [1 << MAW];
  rsp_t          rq[$];
  ev_t           evq[$];
  logic          exp_ack = 1'b0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] exp_dat = '0;
  logic [TW-1:0] exp_tgd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request becomes a response due LAT edges later.
  initial begin
    rsp_t r;
    int   idx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rq.delete();
        exp_ack = 1'b0;
        exp_err = 1'b0;
      end else begin
        ncyc++;
        if (!cyc) rq.delete();
        if (cyc && stb && !stall) begin
          idx   = int'(adr) % (1 << MAW);
          r.due = ncyc + LAT;
          r.ack = 1'b0; r.err = 1'b0; r.dat = '0; r.tgd = '0;
          if (int'(adr) >= (1 << MAW)) begin
            r.err = 1'b1;
          end else begin
            r.ack = 1'b1;
            if (we) begin
              for (int l = 0; l < SW; l++)
                if (sel[l]) m_mem[idx][l*(DW/SW) +: (DW/SW)] = dat_w[l*(DW/SW) +: (DW/SW)];
              if (sel != '0) m_tag[idx] = tgd_w;
            end else begin
              r.dat = m_mem[idx];
              r.tgd = m_tag[idx];
            end
          end
          rq.push_back(r);
        end
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (rq.size() != 0 && rq[0].due == ncyc) begin
          r = rq.pop_front();
          exp_ack = r.ack; exp_err = r.err; exp_dat = r.dat; exp_tgd = r.tgd;
        end
      end
    end
  end

  // Compare DUT outputs to the model every falling edge and log terminations.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mdl_ackerr", 32'({ack, err}), 32'({exp_ack, exp_err}));
        chk("mdl_rty", 32'(rty), 32'(0));
        if (exp_ack || exp_err) chk("mdl_dat", 32'(dat_r), 32'(exp_dat));
        if (exp_ack) chk("mdl_tgd", 32'(tgd_r), 32'(exp_tgd));
`ifndef WB_TGT_MEM_STALL_INJECT_EN
        chk("mdl_stall", 32'(stall), 32'(0));
`endif
        if (ack || err) evq.push_back('{ncyc, ack, err, dat_r});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Present a request at a falling edge and return at the falling edge after acceptance.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [TW-1:0] g, output int at);
    int waits;
    waits = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; tgd_w = g;
    while (stall === 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) chk("stall_bound", 32'(waits), 32'(0));
    @(posedge clk);
    @(negedge clk);
    at = ncyc;
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_rsp(input string name, input logic e_ack, input logic e_err,
                            input logic [DW-1:0] e_dat, input logic [TW-1:0] e_tgd);
    for (int j = 0; j < LAT; j++) begin
      chk({name, "_early"}, 32'({ack, err}), 32'(0));
      @(negedge clk);
    end
    chk({name, "_term"}, 32'({ack, err}), 32'({e_ack, e_err}));
    chk({name, "_dat"}, 32'(dat_r), 32'(e_dat));
    if (e_ack) chk({name, "_tgd"}, 32'(tgd_r), 32'(e_tgd));
  endtask

  vec_t tv[15];

  initial begin
    int at;
    int a0;
    int accs[64];
    cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
    sel = '0; adr = '0; dat_w = '0; tgd_w = '0;

    tv[0]  = '{1'b1, 16'h0005, 16'hA55A, 2'b11, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[1]  = '{1'b0, 16'h0005, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hA55A, 1'b1};
    tv[2]  = '{1'b1, 16'h0003, 16'h1234, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[3]  = '{1'b1, 16'h0003, 16'hFF00, 2'b10, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[4]  = '{1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hFF34, 1'b1};
    tv[5]  = '{1'b1, 16'h0000, 16'h0BAD, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[6]  = '{1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
    tv[7]  = '{1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0BAD, 1'b0};
    tv[8]  = '{1'b1, 16'h8005, 16'h1111, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
    tv[9]  = '{1'b0, 16'h0005, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hA55A, 1'b1};
    tv[10] = '{1'b1, 16'h0003, 16'h00CD, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[11] = '{1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hFFCD, 1'b0};
    tv[12] = '{1'b1, 16'h0003, 16'h7777, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tv[13] = '{1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 16'hFFCD, 1'b0};
    tv[14] = '{1'b0, 16'hFFFF, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_dat", 32'(dat_r), 32'(0));
    chk("rst_tgd", 32'(tgd_r), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < (1 << MAW); i++)
      issue(1'b1, 16'(i), 16'($urandom), 2'b11, 1'($urandom_range(0, 1)), at);
    idle(LAT + 2);

    foreach (tv[i]) begin
      issue(tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, tv[i].tgd, at);
      stb = 1'b0;
      expect_rsp($sformatf("vec%0d", i), tv[i].e_ack, tv[i].e_err, tv[i].e_dat, tv[i].e_tgd);
      @(negedge clk);
    end

    // Back-to-back pipelined reads.
    for (int i = 0; i < 4; i++) issue(1'b1, 16'(i), 16'h0010 + 16'(i), 2'b11, 1'b0, at);
    idle(LAT + 2);
    evq.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(i), 16'h0000, 2'b11, 1'b0, accs[i]);
    idle(LAT + 2);
    chk("b2b_count", 32'(evq.size()), 32'(4));
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      chk($sformatf("b2b%0d_cyc", i), 32'(evq[i].cyc), 32'(accs[i] + LAT));
      chk($sformatf("b2b%0d_dat", i), 32'(evq[i].dat), 32'(16'h0010 + 16'(i)));
    end

    // Cycle abort discards in-flight reads.
    evq.delete();
    issue(1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, at);
    issue(1'b0, 16'h0001, 16'h0000, 2'b11, 1'b0, at);
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_none", 32'(evq.size()), 32'(0));
    issue(1'b0, 16'h0001, 16'h0000, 2'b11, 1'b0, at);
    stb = 1'b0;
    expect_rsp("abort_next", 1'b1, 1'b0, 16'h0011, 1'b0);
    idle(2);

    // Asynchronous reset while a response is on the bus.
    issue(1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, a0);
    issue(1'b0, 16'h0001, 16'h0000, 2'b11, 1'b0, at);
    issue(1'b0, 16'h0002, 16'h0000, 2'b11, 1'b0, at);
    stb = 1'b0;
    while (ncyc < a0 + LAT) @(negedge clk);
    chk("prerst_ack", 32'(ack), 32'(1));
    chk("prerst_dat", 32'(dat_r), 32'(16'h0010));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'(0));
    chk("arst_err", 32'(err), 32'(0));
    chk("arst_stall", 32'(stall), 32'(0));
    chk("arst_dat", 32'(dat_r), 32'(0));
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 16'h0005, 16'h0000, 2'b11, 1'b0, at);
    stb = 1'b0;
    expect_rsp("postrst", 1'b1, 1'b0, 16'hA55A, 1'b1);
    idle(2);

    // 64-request read burst: one termination per request at fixed latency.
    evq.delete();
    for (int i = 0; i < 64; i++)
      issue(1'b0, 16'($urandom_range(0, 255)), 16'h0000, 2'b11, 1'b0, accs[i]);
    idle(LAT + 2);
    chk("burst_count", 32'(evq.size()), 32'(64));
    if (evq.size() == 64) chk("burst_last_cyc", 32'(evq[63].cyc), 32'(accs[63] + LAT));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int            r;
      logic [AW-1:0] a;
      r = int'($urandom_range(0, 15));
      lock = 1'($urandom_range(0, 1));
      if (r == 0) begin
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
      end else if (r < 3) begin
        cyc = 1'b1; stb = 1'b0;
        @(negedge clk);
      end else begin
        a = 16'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) a[15:8] = 8'($urandom_range(1, 255));
        issue(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), at);
      end
    end
    idle(LAT + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
